// File: rtl/wb_regfile_pkg.sv
// ---------------------------------------------------------------------------
// wb_regfile_pkg
// Shared constants for the write-back register file slice: bus and address
// widths, register count, and the named enable/reset levels used when
// comparing control inputs.
// ---------------------------------------------------------------------------
package wb_regfile_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int RegNum     = 32;
  localparam int RegNumLog2 = 5;

  localparam logic [RegBus-1:0]     ZeroWord   = '0;
  localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic ReadEnable   = 1'b1;
  localparam logic ReadDisable  = 1'b0;
  localparam logic RstEnable    = 1'b1;

endpackage

// File: rtl/wb_regfile_if.sv
// ---------------------------------------------------------------------------
// wb_regfile_if
// Bundles the MEM/WB write-back signals together with the ID/EX read ports
// of the register file.
//   master : pipeline side (drives write bundle, read enables/addresses)
//   slave  : register file side (returns read data and HI/LO)
// ---------------------------------------------------------------------------
interface wb_regfile_if;
  import wb_regfile_pkg::*;

  logic [RegAddrBus-1:0] wb_wd;
  logic                  wb_wreg;
  logic [RegBus-1:0]     wb_wdata;
  logic                  wb_whilo;
  logic [RegBus-1:0]     wb_hi;
  logic [RegBus-1:0]     wb_lo;

  logic                  re1;
  logic [RegAddrBus-1:0] raddr1;
  logic [RegBus-1:0]     rdata1;
  logic                  re2;
  logic [RegAddrBus-1:0] raddr2;
  logic [RegBus-1:0]     rdata2;

  logic [RegBus-1:0]     hi_o;
  logic [RegBus-1:0]     lo_o;

  modport master (
    output wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo,
    output re1, raddr1, re2, raddr2,
    input  rdata1, rdata2, hi_o, lo_o
  );

  modport slave (
    input  wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo,
    input  re1, raddr1, re2, raddr2,
    output rdata1, rdata2, hi_o, lo_o
  );

endinterface

// File: rtl/wb_regfile_hilo_reg.sv
// ---------------------------------------------------------------------------
// hilo_reg
// HI/LO register pair. Both halves are written together on a clk edge when
// we=1; reset (synchronous, active-high) clears both.
// Ports: clk, rst, we, hi_i, lo_i (write side); hi_o, lo_o (current value).
// Macro WB_REGFILE_BYPASS_EN: when defined, a write presented this cycle is
// forwarded combinationally to hi_o/lo_o.
// ---------------------------------------------------------------------------
module hilo_reg
  import wb_regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [RegBus-1:0] hi_i,
  input  logic [RegBus-1:0] lo_i,
  output logic [RegBus-1:0] hi_o,
  output logic [RegBus-1:0] lo_o
);

  logic [RegBus-1:0] hi_q, hi_d;
  logic [RegBus-1:0] lo_q, lo_d;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (rst == RstEnable) begin
      hi_d = ZeroWord;
      lo_d = ZeroWord;
    end else if (we == WriteEnable) begin
      hi_d = hi_i;
      lo_d = lo_i;
    end
  end

  always_ff @(posedge clk) begin
    hi_q <= hi_d;
    lo_q <= lo_d;
  end

  always_comb begin
    hi_o = hi_q;
    lo_o = lo_q;
    if (rst == RstEnable) begin
      hi_o = ZeroWord;
      lo_o = ZeroWord;
`ifdef WB_REGFILE_BYPASS_EN
    end else if (we == WriteEnable) begin
      hi_o = hi_i;
      lo_o = lo_i;
`endif
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
// Write-back end of the pipeline: commits the MEM/WB bundle into the 32x32
// GPR file and the HI/LO pair, and serves two combinational GPR read ports
// plus the HI/LO read port.
// Ports: clk, rst (synchronous, active-high), bus (wb_regfile_if.slave:
//   wb_wd/wb_wreg/wb_wdata, wb_whilo/wb_hi/wb_lo, re1/raddr1/rdata1,
//   re2/raddr2/rdata2, hi_o/lo_o).
// Macro WB_REGFILE_BYPASS_EN: when defined, a GPR or HI/LO write presented
// this cycle is forwarded to the read ports in the same cycle.
// ---------------------------------------------------------------------------
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  bus
);

  logic [RegBus-1:0] gpr_q [RegNum];
  logic [RegBus-1:0] gpr_d [RegNum];

  logic byp1, byp2;

  // Priority: reset, r0, forwarded write, enabled stored read, disabled.
  function automatic logic [RegBus-1:0] read_port(
    input logic                  rst_i,
    input logic                  re,
    input logic [RegAddrBus-1:0] raddr,
    input logic                  byp,
    input logic [RegBus-1:0]     byp_data,
    input logic [RegBus-1:0]     stored
  );
    if (rst_i == RstEnable)       return ZeroWord;
    else if (raddr == NOPRegAddr) return ZeroWord;
    else if (byp)                 return byp_data;
    else if (re == ReadEnable)    return stored;
    else                          return ZeroWord;
  endfunction

  always_comb begin
    gpr_d = gpr_q;
    if (rst == RstEnable) begin
      for (int i = 0; i < RegNum; i++) gpr_d[i] = ZeroWord;
    end else if (bus.wb_wreg == WriteEnable && bus.wb_wd != NOPRegAddr) begin
      gpr_d[bus.wb_wd] = bus.wb_wdata;
    end
  end

  always_ff @(posedge clk) begin
    gpr_q <= gpr_d;
  end

`ifdef WB_REGFILE_BYPASS_EN
  always_comb begin
    byp1 = (bus.re1 == ReadEnable) && (bus.wb_wreg == WriteEnable) &&
           (bus.wb_wd == bus.raddr1);
    byp2 = (bus.re2 == ReadEnable) && (bus.wb_wreg == WriteEnable) &&
           (bus.wb_wd == bus.raddr2);
  end
`else
  always_comb begin
    byp1 = 1'b0;
    byp2 = 1'b0;
  end
`endif

  always_comb begin
    bus.rdata1 = read_port(rst, bus.re1, bus.raddr1, byp1, bus.wb_wdata,
                           gpr_q[bus.raddr1]);
    bus.rdata2 = read_port(rst, bus.re2, bus.raddr2, byp2, bus.wb_wdata,
                           gpr_q[bus.raddr2]);
  end

  hilo_reg u_hilo_reg (
    .clk  (clk),
    .rst  (rst),
    .we   (bus.wb_whilo),
    .hi_i (bus.wb_hi),
    .lo_i (bus.wb_lo),
    .hi_o (bus.hi_o),
    .lo_o (bus.lo_o)
  );

endmodule
